// File: rtl/updn_counter_lim.sv
// Up/down counter with programmable limits, variable step and wrap/saturate mode.
// It produces registered terminal-count pulses and sticky over/underflow flags.
module updn_counter_lim #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       STEP_W  = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf,
  output logic              unf,
  output logic              lim_err
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] up_sum;
  logic [EXT_W-1:0] hi_ext;
  logic             dn_borrow;
  logic [WIDTH-1:0] dn_diff;

  logic [WIDTH-1:0] data_nxt;
  logic             tc_up_nxt;
  logic             tc_dn_nxt;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             lim_err_nxt;

  // Extended-width arithmetic so the register never wraps modulo 2^WIDTH.
  always_comb begin
    step_ext  = EXT_W'(step);
    up_sum    = {1'b0, data_out} + step_ext;
    hi_ext    = {1'b0, hi_lim};
    dn_borrow = ({1'b0, data_out} < step_ext);
    dn_diff   = data_out - WIDTH'(step);
  end

  // Next-state: load beats count beats hold.
  always_comb begin
    data_nxt  = data_out;
    tc_up_nxt = 1'b0;
    tc_dn_nxt = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (!ld_cnt) begin
      if (lim_err) begin
        data_nxt = data_in;
      end else if (data_in < lo_lim) begin
        data_nxt = lo_lim;
      end else if (data_in > hi_lim) begin
        data_nxt = hi_lim;
      end else begin
        data_nxt = data_in;
      end
    end else if (count_enb && (step != '0) && !lim_err) begin
      if (updn_cnt) begin
        if (up_sum < hi_ext) begin
          data_nxt = WIDTH'(up_sum);
        end else if (up_sum == hi_ext) begin
          data_nxt  = hi_lim;
          tc_up_nxt = 1'b1;
        end else begin
          data_nxt  = sat_mode ? hi_lim : lo_lim;
          tc_up_nxt = 1'b1;
          ovf_set   = 1'b1;
        end
      end else begin
        // A borrow means the result went below zero, hence below any lo_lim.
        if (!dn_borrow && (dn_diff > lo_lim)) begin
          data_nxt = dn_diff;
        end else if (!dn_borrow && (dn_diff == lo_lim)) begin
          data_nxt  = lo_lim;
          tc_dn_nxt = 1'b1;
        end else begin
          data_nxt  = sat_mode ? lo_lim : hi_lim;
          tc_dn_nxt = 1'b1;
          unf_set   = 1'b1;
        end
      end
    end

    ovf_nxt     = ovf_set | (ovf & ~clr_flags);
    unf_nxt     = unf_set | (unf & ~clr_flags);
    lim_err_nxt = (hi_lim < lo_lim);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_out <= RST_VAL;
      tc_up    <= 1'b0;
      tc_dn    <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      lim_err  <= 1'b0;
    end else begin
      data_out <= data_nxt;
      tc_up    <= tc_up_nxt;
      tc_dn    <= tc_dn_nxt;
      ovf      <= ovf_nxt;
      unf      <= unf_nxt;
      lim_err  <= lim_err_nxt;
    end
  end

endmodule

// File: tb/tb_updn_counter_lim.sv
// Directed, table-driven bench for updn_counter_lim (WIDTH=16, STEP_W=4).
module tb_updn_counter_lim;

  logic        clk;
  logic        rst_;
  logic [15:0] data_in;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic        sat_mode;
  logic [3:0]  step;
  logic [15:0] lo_lim;
  logic [15:0] hi_lim;
  logic        clr_flags;
  logic [15:0] data_out;
  logic        tc_up;
  logic        tc_dn;
  logic        ovf;
  logic        unf;
  logic        lim_err;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        ld;
    logic        up;
    logic        en;
    logic        sat;
    logic [3:0]  stp;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] din;
    logic        clr;
    logic [15:0] e_dout;
    logic        e_tcu;
    logic        e_tcd;
    logic        e_ovf;
    logic        e_unf;
    logic        e_lerr;
  } vec_t;

  vec_t vecs[$];

  updn_counter_lim #(.WIDTH(16), .STEP_W(4), .RST_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .sat_mode  (sat_mode),
    .step      (step),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .clr_flags (clr_flags),
    .data_out  (data_out),
    .tc_up     (tc_up),
    .tc_dn     (tc_dn),
    .ovf       (ovf),
    .unf       (unf),
    .lim_err   (lim_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] d, input logic tu, input logic td,
                         input logic ov, input logic un, input logic le);
    chk({name, ".data_out"}, 32'(data_out), 32'(d));
    chk({name, ".tc_up"},    32'(tc_up),    32'(tu));
    chk({name, ".tc_dn"},    32'(tc_dn),    32'(td));
    chk({name, ".ovf"},      32'(ovf),      32'(ov));
    chk({name, ".unf"},      32'(unf),      32'(un));
    chk({name, ".lim_err"},  32'(lim_err),  32'(le));
  endtask

  task automatic add(input string name, input logic ld, input logic up, input logic en,
                     input logic sat, input logic [3:0] stp, input logic [15:0] lo,
                     input logic [15:0] hi, input logic [15:0] din, input logic clr,
                     input logic [15:0] e_dout, input logic e_tcu, input logic e_tcd,
                     input logic e_ovf, input logic e_unf, input logic e_lerr);
    vec_t v;
    v.name = name; v.ld = ld; v.up = up; v.en = en; v.sat = sat; v.stp = stp;
    v.lo = lo; v.hi = hi; v.din = din; v.clr = clr;
    v.e_dout = e_dout; v.e_tcu = e_tcu; v.e_tcd = e_tcd;
    v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_lerr = e_lerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic up, input logic en, input logic sat,
                       input logic [3:0] stp, input logic [15:0] lo, input logic [15:0] hi,
                       input logic [15:0] din, input logic clr);
    ld_cnt = ld; updn_cnt = up; count_enb = en; sat_mode = sat; step = stp;
    lo_lim = lo; hi_lim = hi; data_in = din; clr_flags = clr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //   name        ld up en sa stp  lo       hi       din      clr  dout     tu td ov un le
    add("idle",      1, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    add("ld_clmphi", 0, 0, 0, 0, 0, 16'h0010, 16'h00F0, 16'h0200, 0, 16'h00F0, 0, 0, 0, 0, 0);
    add("ld_clmplo", 0, 0, 0, 0, 0, 16'h0010, 16'h00F0, 16'h0005, 0, 16'h0010, 0, 0, 0, 0, 0);
    add("ld_wenb",   0, 1, 1, 0, 1, 16'h0010, 16'h00F0, 16'h0080, 0, 16'h0080, 0, 0, 0, 0, 0);
    add("ld_1e",     0, 1, 0, 0, 0, 16'h0010, 16'h0020, 16'h001E, 0, 16'h001E, 0, 0, 0, 0, 0);
    add("up_wrap",   1, 1, 1, 0, 3, 16'h0010, 16'h0020, 16'h0000, 0, 16'h0010, 1, 0, 1, 0, 0);
    add("up_after",  1, 1, 1, 0, 3, 16'h0010, 16'h0020, 16'h0000, 0, 16'h0013, 0, 0, 1, 0, 0);
    add("ld_6_clr",  0, 1, 0, 0, 0, 16'h0000, 16'h0008, 16'h0006, 1, 16'h0006, 0, 0, 0, 0, 0);
    add("up_exact",  1, 1, 1, 0, 2, 16'h0000, 16'h0008, 16'h0000, 0, 16'h0008, 1, 0, 0, 0, 0);
    add("step0",     1, 1, 1, 0, 0, 16'h0000, 16'h0008, 16'h0000, 0, 16'h0008, 0, 0, 0, 0, 0);
    add("sat_athi",  1, 1, 1, 1, 1, 16'h0000, 16'h0008, 16'h0000, 0, 16'h0008, 1, 0, 1, 0, 0);
    add("clr_set",   1, 1, 1, 1, 1, 16'h0000, 16'h0008, 16'h0000, 1, 16'h0008, 1, 0, 1, 0, 0);
    add("clr_only",  1, 1, 0, 1, 1, 16'h0000, 16'h0008, 16'h0000, 1, 16'h0008, 0, 0, 0, 0, 0);
    add("ld_2",      0, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0002, 0, 16'h0002, 0, 0, 0, 0, 0);
    add("dn_sat",    1, 0, 1, 1, 5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0);
    add("dn_sat2",   1, 0, 1, 1, 5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0);
    add("dn_hold",   1, 0, 0, 1, 1, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);
    add("ld_6_clr2", 0, 0, 0, 0, 0, 16'h0004, 16'h0040, 16'h0006, 1, 16'h0006, 0, 0, 0, 0, 0);
    add("dn_exact",  1, 0, 1, 0, 2, 16'h0004, 16'h0040, 16'h0000, 0, 16'h0004, 0, 1, 0, 0, 0);
    add("dn_wrap",   1, 0, 1, 0, 1, 16'h0004, 16'h0040, 16'h0000, 0, 16'h0040, 0, 1, 0, 1, 0);
    add("dn_norm",   1, 0, 1, 0, 3, 16'h0004, 16'h0040, 16'h0000, 0, 16'h003D, 0, 0, 0, 1, 0);
    add("abv_hi",    1, 1, 1, 1, 1, 16'h0004, 16'h0030, 16'h0000, 0, 16'h0030, 1, 0, 1, 1, 0);
    add("lim_set",   1, 1, 0, 0, 0, 16'h0009, 16'h0005, 16'h0000, 1, 16'h0030, 0, 0, 0, 0, 1);
    add("lim_hold",  1, 1, 1, 0, 1, 16'h0009, 16'h0005, 16'h0000, 0, 16'h0030, 0, 0, 0, 0, 1);
    add("lim_ld7",   0, 1, 1, 0, 1, 16'h0009, 16'h0005, 16'h0007, 0, 16'h0007, 0, 0, 0, 0, 1);
    add("lim_ldraw", 0, 1, 0, 0, 0, 16'h0009, 16'h0005, 16'h0100, 0, 16'h0100, 0, 0, 0, 0, 1);
    add("lim_clr",   1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0100, 0, 0, 0, 0, 0);
    add("up_stepF",  1, 1, 1, 0, 15, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h010F, 0, 0, 0, 0, 0);
    add("ld_fffc",   0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFC, 0, 16'hFFFC, 0, 0, 0, 0, 0);
    add("up_top",    1, 1, 1, 0, 15, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 1, 0, 1, 0, 0);

    // Async reset with no clock edge.
    rst_ = 1'b0;
    drive(1, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 0);
    #1;
    chk_all("rst0", 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ld, vecs[i].up, vecs[i].en, vecs[i].sat, vecs[i].stp,
            vecs[i].lo, vecs[i].hi, vecs[i].din, vecs[i].clr);
      @(posedge clk);
      #1;
      chk_all(vecs[i].name, vecs[i].e_dout, vecs[i].e_tcu, vecs[i].e_tcd,
              vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_lerr);
    end

    // Mid-run async reset: ovf is still set from the last vector.
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h1234, 0);
    @(posedge clk);
    #1;
    chk_all("ld_1234", 16'h1234, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 1, 0, 1, 16'h0000, 16'hFFFF, 16'h0000, 0);
    @(posedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    chk_all("rst_async", 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 0);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_idle", 16'h0000, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updn_counter_lim.md
Name: updn_counter_lim

Overview:
Parametrised up/down counter with active-low synchronous load, programmable low/high limits, variable step, and a wrap/saturate mode. It flags limit crossings with one-cycle terminal-count pulses and sticky over/underflow flags. It is the general counting element for timers, credit counters and address generators. It replaces fixed 16-bit, step-1, free-wrapping counters.

Parameters:
WIDTH, 16, counter/data width in bits (>=2)
STEP_W, 4, width of step input (1..WIDTH)
RST_VAL, 0, data_out value on reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
rst_  input  1  asynchronous active-low reset
data_in  input  WIDTH  load value
ld_cnt  input  1  active-low synchronous load
updn_cnt  input  1  1 = count up, 0 = count down
count_enb  input  1  count enable, active high
sat_mode  input  1  1 = saturate at limit, 0 = wrap to opposite limit
step  input  STEP_W  increment/decrement amount; 0 = hold
lo_lim  input  WIDTH  lower count limit (unsigned)
hi_lim  input  WIDTH  upper count limit (unsigned)
clr_flags  input  1  synchronous clear of ovf/unf
data_out  output  WIDTH  registered count
tc_up  output  1  one-cycle pulse: up-count reached or crossed hi_lim
tc_dn  output  1  one-cycle pulse: down-count reached or crossed lo_lim
ovf  output  1  sticky: up-count attempted past hi_lim
unf  output  1  sticky: down-count attempted past lo_lim
lim_err  output  1  registered: hi_lim < lo_lim

Behaviour:
- Reset (rst_=0, async): data_out=RST_VAL, tc_up=0, tc_dn=0, ovf=0, unf=0, lim_err=0. Release is synchronous to the next clk edge; no count or load happens on that edge's reset assertion.
- Priority per clk edge: load > count > hold.
- Load (ld_cnt=0): data_out <= data_in clamped into [lo_lim, hi_lim] (below lo_lim gives lo_lim; above hi_lim gives hi_lim). No tc/ovf/unf effect. The load applies regardless of count_enb.
- lim_err is registered each cycle from (hi_lim < lo_lim). While lim_err=1, counting is suppressed (data_out holds), but load still operates, with data_in taken unclamped.
- Count (ld_cnt=1, count_enb=1, step!=0, lim_err=0). Arithmetic uses WIDTH+1 bits, zero-extending step; no modular wrap of the WIDTH-bit register is ever exposed.
  - Up: nxt = data_out + step.
    - nxt < hi_lim: data_out <= nxt.
    - nxt == hi_lim: data_out <= hi_lim; tc_up=1 next cycle.
    - nxt > hi_lim: tc_up=1 and ovf set. sat_mode=1 gives data_out <= hi_lim. sat_mode=0 gives data_out <= lo_lim; excess is discarded.
  - Down: nxt = data_out - step, computed signed.
    - nxt > lo_lim: data_out <= nxt.
    - nxt == lo_lim: data_out <= lo_lim; tc_dn=1.
    - nxt < lo_lim (including below 0): tc_dn=1 and unf set. sat_mode=1 gives lo_lim; sat_mode=0 gives hi_lim.
  - Already at hi_lim and counting up in saturate mode: data_out holds, tc_up pulses, ovf sets. The same holds at lo_lim going down.
- If data_out is outside the limits because the limits changed mid-run, the next count step applies the rules above unchanged. Example: data_out > hi_lim counting up is treated as an over-limit event.
- tc_up and tc_dn are registered, asserted exactly one cycle per triggering edge, and never both high. Both are 0 on load or hold cycles.
- ovf/unf: clr_flags=1 clears them. If a set condition occurs on the same edge as clr_flags, set wins.
- Latency: every output changes only on the clk edge after its cause (one cycle). No combinational input-to-output paths.

Test Plan:
- Reset: drive rst_=0 mid-count with data_out=0x1234 -> all outputs 0 immediately, no clk needed. Release, then one idle cycle -> data_out stays 0.
- Load clamp: lo=0x0010, hi=0x00F0, ld_cnt=0, data_in=0x0200 -> data_out=0x00F0. data_in=0x0005 -> data_out=0x0010. With count_enb=1 during load -> still loads.
- Up wrap: lo=0x10, hi=0x20, data_out=0x1E, step=3, updn=1, sat=0 -> data_out=0x10, tc_up=1 for one cycle, ovf=1. Next edge -> 0x13, tc_up=0, ovf remains 1.
- Down saturate: lo=0, hi=0xFFFF, data_out=2, step=5, updn=0, sat=1 -> data_out=0, tc_dn=1, unf=1. A further edge -> data_out holds at 0, tc_dn pulses again.
- Exact hit: lo=0, hi=8, data_out=6, step=2, up -> data_out=8, tc_up=1, ovf=0.
- Flags and errors: ovf=1 with clr_flags=1 and an overflow on the same edge -> ovf stays 1. clr_flags alone -> ovf=0. Set hi=0x05, lo=0x09 -> lim_err=1 next cycle, count_enb=1 holds data_out, and a load of 0x07 gives data_out=0x07.
